// File: rtl/seq_detector_param.sv
// Parameterised serial pattern detector with overlap control and a load-able pattern.
// Define SEQ_DET_COUNT_EN to build the saturating match counter; otherwise match_cnt_o is tied to 0.
module seq_detector_param #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter logic [PAT_W-1:0] RESET_PAT = PAT_W'(4'b1011)
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             in_i,
    input  logic             valid_i,
    input  logic             load_i,
    input  logic [PAT_W-1:0] pattern_i,
    input  logic             overlap_i,
    output logic             detected_o,
    output logic             armed_o,
    output logic [CNT_W-1:0] match_cnt_o
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_W);

    typedef enum logic {
        FILL,
        ARMED
    } state_t;

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [PAT_W-1:0]   hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               detected_q, detected_d;

    // Load wins over an accepted bit; a non-overlapping hit restarts the fill.
    always_comb begin
        pat_d      = pat_q;
        hist_d     = hist_q;
        fill_d     = fill_q;
        detected_d = 1'b0;
        if (load_i) begin
            pat_d  = pattern_i;
            hist_d = '0;
            fill_d = '0;
        end else if (valid_i) begin
            hist_d = {hist_q[PAT_W-2:0], in_i};
            fill_d = (fill_q == FULL) ? FULL : fill_q + FILL_W'(1);
            if ((fill_d == FULL) && (hist_d == pat_q)) begin
                detected_d = 1'b1;
                if (!overlap_i) begin
                    fill_d = '0;
                end
            end
        end
        state_d = (fill_d == FULL) ? ARMED : FILL;
    end

    always_ff @(posedge clk) begin
        if (!reset_i) begin
            state_q    <= FILL;
            pat_q      <= RESET_PAT;
            hist_q     <= '0;
            fill_q     <= '0;
            detected_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pat_q      <= pat_d;
            hist_q     <= hist_d;
            fill_q     <= fill_d;
            detected_q <= detected_d;
        end
    end

    assign detected_o = detected_q;
    assign armed_o    = (state_q == ARMED);

`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (detected_d && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt_o = cnt_q;
`else
    assign match_cnt_o = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: directed scenarios plus random traffic
// compared against a queue-based reference model of the detection rules.
module tb_seq_detector_param;

    localparam int PAT_W = 4;
    localparam int CNT_W = 8;
    localparam int MAX_CNT = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset_i = 1'b0;
    logic             in_i = 1'b0;
    logic             valid_i = 1'b0;
    logic             load_i = 1'b0;
    logic [PAT_W-1:0] pattern_i = '0;
    logic             overlap_i = 1'b0;
    logic             detected_o;
    logic             armed_o;
    logic [CNT_W-1:0] match_cnt_o;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: accepted bits since the last restart, oldest first.
    bit q[$];
    int unsigned m_pat;
    int m_cnt;
    bit m_det;

    seq_detector_param #(
        .PAT_W(PAT_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset_i(reset_i),
        .in_i(in_i),
        .valid_i(valid_i),
        .load_i(load_i),
        .pattern_i(pattern_i),
        .overlap_i(overlap_i),
        .detected_o(detected_o),
        .armed_o(armed_o),
        .match_cnt_o(match_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        if (observed != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelStep(input bit rst, input bit valid, input bit din,
                             input bit load, input int unsigned patv, input bit ovl);
        int unsigned v;
        m_det = 1'b0;
        if (!rst) begin
            q.delete();
            m_pat = 4'b1011;
            m_cnt = 0;
        end else if (load) begin
            q.delete();
            m_pat = patv;
            m_cnt = 0;
        end else if (valid) begin
            q.push_back(din);
            if (q.size() > PAT_W) void'(q.pop_front());
            if (q.size() == PAT_W) begin
                v = 0;
                foreach (q[i]) v = (v << 1) | q[i];
                if (v == m_pat) begin
                    m_det = 1'b1;
                    if (m_cnt < MAX_CNT) m_cnt++;
                    if (!ovl) q.delete();
                end
            end
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit valid, input bit din,
                                 input bit load, input int unsigned patv, input bit ovl);
        int exp_cnt;
        @(negedge clk);
        reset_i   = rst;
        valid_i   = valid;
        in_i      = din;
        load_i    = load;
        pattern_i = patv[PAT_W-1:0];
        overlap_i = ovl;
        @(posedge clk);
        modelStep(rst, valid, din, load, patv, ovl);
        #1;
`ifdef SEQ_DET_COUNT_EN
        exp_cnt = m_cnt;
`else
        exp_cnt = 0;
`endif
        checkOutput("detected", int'(detected_o), int'(m_det));
        checkOutput("armed", int'(armed_o), (q.size() == PAT_W) ? 1 : 0);
        checkOutput("match_cnt", int'(match_cnt_o), exp_cnt);
    endtask

    task automatic sendBit(input bit din, input bit ovl);
        applyStimulus(1'b1, 1'b1, din, 1'b0, 0, ovl);
    endtask

    task automatic idle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        bit stream [7];
        stream = '{1, 0, 1, 1, 0, 1, 1};

        doReset();
        doReset();

        // Default pattern, single hit
        sendBit(1, 1); sendBit(0, 1); sendBit(1, 1); sendBit(1, 1);
        checkOutput("dir_hit_default", int'(detected_o), 1);
        idle();
        checkOutput("dir_pulse_one_cycle", int'(detected_o), 0);

        // Overlapping and non-overlapping streams
        doReset();
        foreach (stream[i]) sendBit(stream[i], 1);
        doReset();
        foreach (stream[i]) begin
            sendBit(stream[i], 0);
            if (i == 3) checkOutput("dir_nonoverlap_disarm", int'(armed_o), 0);
        end

        // Gaps in valid
        doReset();
        sendBit(1, 1); sendBit(0, 1);
        repeat (3) idle();
        sendBit(1, 1); sendBit(1, 1);

        // Load with valid in the same cycle, then new pattern
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b1);
        checkOutput("dir_load_clears_cnt", int'(match_cnt_o), 0);
        sendBit(0, 1); sendBit(1, 1); sendBit(1, 1); sendBit(0, 1);
        checkOutput("dir_hit_loaded", int'(detected_o), 1);

        // Reset mid-sequence discards history
        doReset();
        sendBit(1, 1); sendBit(0, 1); sendBit(1, 1);
        doReset();
        checkOutput("dir_reset_armed", int'(armed_o), 0);
        sendBit(1, 1);

        // Counter saturation with an all-ones pattern
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b0);
        repeat (MAX_CNT + 8) sendBit(1, 1);

        // Random traffic
        doReset();
        for (int n = 0; n < 3000; n++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            if (r < 2) doReset();
            else if (r < 5) applyStimulus(1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                                          1'b1, $urandom_range(0, 15), 1'b0);
            else applyStimulus(1'b1, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                               1'b0, 0, $urandom_range(0, 1) == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 Parameter PAT_W, default 4, SHALL set pattern length in bits; legal range 2..16.
REQ-002 Parameter CNT_W, default 8, SHALL set match counter width; legal range 1..16.
REQ-003 Parameter RESET_PAT, default 4'b1011 (width PAT_W), SHALL set the pattern value loaded at reset.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset_i  input  1  reset, synchronous, active-low.
REQ-006 in_i  input  1  serial data bit; first-received bit ends up in the MSB position of the pattern comparison.
REQ-007 valid_i  input  1  in_i is accepted on an edge only when valid_i=1.
REQ-008 load_i  input  1  loads pattern_i into the pattern register on the edge.
REQ-009 pattern_i  input  PAT_W  new pattern value, sampled only when load_i=1.
REQ-010 overlap_i  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-011 detected_o  output  1  registered one-cycle match pulse.
REQ-012 armed_o  output  1  high while PAT_W valid bits are held in history.
REQ-013 match_cnt_o  output  CNT_W  saturating count of detections.

Function
REQ-014 Internal state SHALL be pattern register pat, history shift register hist (PAT_W bits), fill counter fill (0..PAT_W), FSM state {FILL, ARMED}.
REQ-015 Accepted bit (valid_i=1, load_i=0): hist_next = {hist[PAT_W-2:0], in_i}; fill saturates at PAT_W.
REQ-016 FSM SHALL be FILL while fill<PAT_W and ARMED while fill==PAT_W; armed_o = (state==ARMED).
REQ-017 detected_o SHALL be 1 in the cycle after an accepting edge iff fill_next==PAT_W and hist_next==pat; otherwise 0.
REQ-018 Latency: final pattern bit accepted at edge k -> detected_o high from edge k to edge k+1, exactly one cycle.
REQ-019 On detection with overlap_i=1, fill SHALL stay PAT_W; state stays ARMED.
REQ-020 On detection with overlap_i=0, fill SHALL go to 0 and state to FILL; the next detection needs PAT_W new accepted bits.
REQ-021 overlap_i SHALL be sampled only on the detecting edge.
REQ-022 valid_i=0 edge: hist, fill, state unchanged; detected_o=0.
REQ-023 load_i=1 edge: pat<=pattern_i; hist<=0; fill<=0; state<=FILL; detected_o<=0; match counter cleared; in_i discarded even if valid_i=1 (load wins).
REQ-024 Each detected_o pulse SHALL increment match_cnt_o by 1, saturating at 2^CNT_W-1 with no wrap.
REQ-025 Comparison is whole-pattern exact; no don't-care bits.

Reset
REQ-026 reset_i=0 at an edge SHALL set pat=RESET_PAT, hist=0, fill=0, state=FILL, detected_o=0, armed_o=0, match_cnt_o=0.
REQ-027 Reset SHALL take priority over load_i and valid_i.
REQ-028 Reset mid-sequence SHALL discard partial history; no detection may use bits accepted before reset.
REQ-029 Outputs are undefined before the first clock edge with reset_i=0.

Configuration
REQ-030 Macro SEQ_DET_COUNT_EN SHALL control the match counter.
REQ-031 Defined: the counter is implemented per REQ-024.
REQ-032 Undefined: no counter flops; match_cnt_o tied to 0; all other behaviour identical.

Verification
REQ-033 Default pattern 1011: reset, then valid bits 1,0,1,1 -> detected_o=1 for one cycle after the 4th bit; match_cnt_o=1; armed_o=1 after the 4th bit.
REQ-034 Stream 1,0,1,1,0,1,1 with overlap_i=1 -> two pulses, after bits 4 and 7; with overlap_i=0 -> one pulse after bit 4, and armed_o=0 after bit 4.
REQ-035 Bits 1,0 then valid_i=0 for 3 cycles then 1,1 -> one pulse after the final bit; no pulse during the gaps.
REQ-036 Load pattern_i=4'b0110 with valid_i=1 in the same cycle (bit discarded), then 0,1,1,0 -> pulse after bit 4; match_cnt_o cleared to 0 at the load edge, then 1.
REQ-037 Bits 1,0,1, then reset_i=0 for one cycle, then 1 -> no pulse; all outputs 0 after the reset edge.
REQ-038 CNT_W=2, SEQ_DET_COUNT_EN defined, overlap_i=1, stream of 5 matches -> match_cnt_o=3 (saturated). Macro undefined -> match_cnt_o stays 0.
